// File: rtl/sar_adc_ctrl.sv
// Successive-approximation ADC controller: drives the R-2R DAC trial code and
// runs a binary search on the synchronized comparator decision.
module sar_adc_ctrl #(
  parameter int WIDTH         = 8,
  parameter int SETTLE_CYCLES = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             cont,
  input  logic             abort,
  input  logic             cmp_in,
  output logic [WIDTH-1:0] dac_code,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             result_valid
);

  localparam int IDX_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam int CNT_W = $clog2(SETTLE_CYCLES);
  localparam logic [WIDTH-1:0] MSB_CODE = {1'b1, {(WIDTH-1){1'b0}}};
  localparam logic [IDX_W-1:0] TOP_IDX  = IDX_W'(WIDTH - 1);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(SETTLE_CYCLES - 1);

  // The per-bit wait must cover the two synchronizer stages plus analog settling.
  if (SETTLE_CYCLES < 3) begin : g_bad_settle
    $error("sar_adc_ctrl: SETTLE_CYCLES must be >= 3");
  end
  if ((WIDTH < 2) || (WIDTH > 8)) begin : g_bad_width
    $error("sar_adc_ctrl: WIDTH must be in 2..8");
  end

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETTLE = 2'd1,
    ST_DECIDE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [IDX_W-1:0] bit_idx_q, bit_idx_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] dac_code_q, dac_code_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             valid_q, valid_d;
  logic             cmp_meta_q, cmp_s_q;
  logic [WIDTH-1:0] code_trial_s;
  logic [IDX_W-1:0] idx_m1_s;

  assign idx_m1_s = bit_idx_q - IDX_W'(1);

  // Two-flop synchronizer for the asynchronous comparator output.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cmp_meta_q <= 1'b0;
      cmp_s_q    <= 1'b0;
    end else begin
      cmp_meta_q <= cmp_in;
      cmp_s_q    <= cmp_meta_q;
    end
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      bit_idx_q  <= {IDX_W{1'b0}};
      cnt_q      <= {CNT_W{1'b0}};
      dac_code_q <= {WIDTH{1'b0}};
      result_q   <= {WIDTH{1'b0}};
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      valid_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      bit_idx_q  <= bit_idx_d;
      cnt_q      <= cnt_d;
      dac_code_q <= dac_code_d;
      result_q   <= result_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      valid_q    <= valid_d;
    end
  end

  // Next-state logic: abort wins over everything, including a completion.
  always_comb begin
    state_d      = state_q;
    bit_idx_d    = bit_idx_q;
    cnt_d        = cnt_q;
    dac_code_d   = dac_code_q;
    result_d     = result_q;
    busy_d       = busy_q;
    done_d       = 1'b0;
    valid_d      = valid_q;
    code_trial_s = dac_code_q;

    if (abort) begin
      state_d    = ST_IDLE;
      dac_code_d = {WIDTH{1'b0}};
      busy_d     = 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          busy_d = 1'b0;
          if (start) begin
            dac_code_d = MSB_CODE;
            bit_idx_d  = TOP_IDX;
            cnt_d      = {CNT_W{1'b0}};
            busy_d     = 1'b1;
            state_d    = ST_SETTLE;
          end else begin
            state_d = ST_IDLE;
          end
        end
        ST_SETTLE: begin
          if (cnt_q == LAST_CNT) begin
            state_d = ST_DECIDE;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        ST_DECIDE: begin
          if (cmp_s_q) begin
            code_trial_s[bit_idx_q] = 1'b1;
          end else begin
            code_trial_s[bit_idx_q] = 1'b0;
          end
          if (bit_idx_q != {IDX_W{1'b0}}) begin
            code_trial_s[idx_m1_s] = 1'b1;
            dac_code_d = code_trial_s;
            bit_idx_d  = idx_m1_s;
            cnt_d      = {CNT_W{1'b0}};
            state_d    = ST_SETTLE;
          end else begin
            result_d = code_trial_s;
            done_d   = 1'b1;
            valid_d  = 1'b1;
            // Continuous mode re-arms the MSB trial on the completing edge.
            if (cont) begin
              dac_code_d = MSB_CODE;
              bit_idx_d  = TOP_IDX;
              cnt_d      = {CNT_W{1'b0}};
              busy_d     = 1'b1;
              state_d    = ST_SETTLE;
            end else begin
              dac_code_d = code_trial_s;
              busy_d     = 1'b0;
              state_d    = ST_IDLE;
            end
          end
        end
        default: begin
          state_d    = ST_IDLE;
          dac_code_d = {WIDTH{1'b0}};
          busy_d     = 1'b0;
        end
      endcase
    end
  end

  assign dac_code     = dac_code_q;
  assign busy         = busy_q;
  assign done         = done_q;
  assign result       = result_q;
  assign result_valid = valid_q;

endmodule
